// File: rtl/digests_responder_pkg.sv
// digests_responder_pkg: shared DIGESTS header constants, FSM states and helpers
package digests_responder_pkg;

    localparam int SIZE_OF_HEADER_IN_BYTES = 4;

    localparam logic [7:0] SPDM_PROTO_VER   = 8'h01;
    localparam logic [7:0] MSG_TYPE_DIGESTS = 8'h01;
    localparam logic [7:0] DIGESTS_PARAM1   = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DIGEST = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Number of populated slots in a (zero-extended) mask of up to eight slots.
    function automatic logic [3:0] popcount8(input logic [7:0] m);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, m[i]};
        return n;
    endfunction

endpackage

// File: rtl/digests_responder_if.sv
// digests_responder_if: byte-serial valid/ready response stream with framing
interface digests_responder_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sop;
    logic       tx_eop;

    modport master (output tx_data, tx_valid, tx_sop, tx_eop, input tx_ready);
    modport slave  (input tx_data, tx_valid, tx_sop, tx_eop, output tx_ready);

endinterface

// File: rtl/digests_responder_slot_sel.sv
// digests_responder_slot_sel: finds the lowest populated slot at or above a base index
module digests_responder_slot_sel #(
    parameter int NUM_SLOTS = 8,
    parameter int SW        = 3
) (
    input  logic [NUM_SLOTS-1:0] mask_i,
    input  logic [SW:0]          base_i,
    output logic [SW-1:0]        slot_o,
    output logic                 last_o
);

    // Priority-encode upward from base; last_o says nothing populated lies above the pick.
    always_comb begin
        slot_o = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (mask_i[i] && (SW + 1)'(i) >= base_i) slot_o = SW'(i);
        last_o = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (mask_i[i] && SW'(i) > slot_o) last_o = 1'b0;
    end

endmodule

// File: rtl/digests_responder.sv
// digests_responder: snapshots slot digests on GET_DIGESTS and streams the DIGESTS response
module digests_responder
    import digests_responder_pkg::*;
#(
    parameter int          NUM_SLOTS    = 8,
    parameter int          DIGEST_BYTES = 32,
    parameter logic [7:0]  PROTO_VER    = SPDM_PROTO_VER,
    parameter logic [7:0]  MSG_TYPE     = MSG_TYPE_DIGESTS,
    parameter logic [7:0]  PARAM1       = DIGESTS_PARAM1,
    localparam int         LEN_W        = $clog2(SIZE_OF_HEADER_IN_BYTES + NUM_SLOTS * DIGEST_BYTES + 1)
) (
    input  logic                                clk,
    input  logic                                reset_L,
    input  logic                                req_in,
    input  logic [NUM_SLOTS-1:0]                slot_mask_in,
    input  logic [NUM_SLOTS*DIGEST_BYTES*8-1:0] digest_in,
    digests_responder_if.master                 tx,
    output logic [LEN_W-1:0]                    resp_len,
    output logic                                busy,
    output logic                                done,
    output logic                                req_drop
);

    localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(DIGEST_BYTES + SIZE_OF_HEADER_IN_BYTES);
    localparam int DW = NUM_SLOTS * DIGEST_BYTES * 8;

    state_t               state_q;
    logic [NUM_SLOTS-1:0] mask_q;
    logic [DW-1:0]        dig_q;
    logic [SW-1:0]        slot_q;
    logic                 last_q;
    logic [CW-1:0]        cnt_q;
    logic [LEN_W-1:0]     len_q;
    logic                 busy_q, done_q, drop_q;
    logic                 valid_q, sop_q, eop_q;
    logic [7:0]           data_q;

    logic [SW:0]          base;
    logic [SW-1:0]        nxt_slot;
    logic                 nxt_last;
    logic [CW-1:0]        cnt_nxt;
    logic [7:0]           hdr_byte;
    logic                 fin;

    // Byte b (0 = most significant) of the snapshot digest for slot s.
    function automatic logic [7:0] dig_byte(input logic [SW-1:0] s, input logic [CW-1:0] b);
        logic [31:0] idx;
        idx = 32'(s) * 32'(DIGEST_BYTES) + 32'(DIGEST_BYTES) - 32'd1 - 32'(b);
        return 8'(dig_q >> {idx, 3'b000});
    endfunction

    assign base     = state_q == ST_DIGEST ? {1'b0, slot_q} + (SW + 1)'(1) : '0;
    assign cnt_nxt  = cnt_q + CW'(1);
    assign hdr_byte = cnt_nxt == CW'(1) ? MSG_TYPE : cnt_nxt == CW'(2) ? PARAM1 : 8'(mask_q);
    assign fin      = tx.tx_ready && ((state_q == ST_HEADER && cnt_q == CW'(3) && mask_q == '0) ||
                                      (state_q == ST_DIGEST && cnt_q == CW'(DIGEST_BYTES - 1) && last_q));

    digests_responder_slot_sel #(.NUM_SLOTS(NUM_SLOTS), .SW(SW)) u_slot_sel (
        .mask_i (mask_q),
        .base_i (base),
        .slot_o (nxt_slot),
        .last_o (nxt_last)
    );

    // Response FSM: registered stream outputs only move when the sink accepts a byte.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            dig_q   <= '0;
            slot_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            drop_q <= req_in && state_q != ST_IDLE;
            if (fin) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
                data_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: if (req_in) begin
                        state_q <= ST_HEADER;
                        mask_q  <= slot_mask_in;
                        dig_q   <= digest_in;
                        len_q   <= LEN_W'(SIZE_OF_HEADER_IN_BYTES +
                                          int'(popcount8(8'(slot_mask_in))) * DIGEST_BYTES);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        sop_q   <= 1'b1;
                        eop_q   <= 1'b0;
                        data_q  <= PROTO_VER;
                    end
                    ST_HEADER: if (tx.tx_ready) begin
                        sop_q <= 1'b0;
                        if (cnt_q == CW'(3)) begin
                            state_q <= ST_DIGEST;
                            slot_q  <= nxt_slot;
                            last_q  <= nxt_last;
                            cnt_q   <= '0;
                            data_q  <= dig_byte(nxt_slot, CW'(0));
                            eop_q   <= nxt_last && DIGEST_BYTES == 1;
                        end else begin
                            cnt_q  <= cnt_nxt;
                            data_q <= hdr_byte;
                            eop_q  <= cnt_nxt == CW'(3) && mask_q == '0;
                        end
                    end
                    ST_DIGEST: if (tx.tx_ready) begin
                        if (cnt_q == CW'(DIGEST_BYTES - 1)) begin
                            slot_q <= nxt_slot;
                            last_q <= nxt_last;
                            cnt_q  <= '0;
                            data_q <= dig_byte(nxt_slot, CW'(0));
                            eop_q  <= nxt_last && DIGEST_BYTES == 1;
                        end else begin
                            cnt_q  <= cnt_nxt;
                            data_q <= dig_byte(slot_q, cnt_nxt);
                            eop_q  <= last_q && cnt_nxt == CW'(DIGEST_BYTES - 1);
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign tx.tx_sop   = sop_q;
    assign tx.tx_eop   = eop_q;
    assign resp_len    = len_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign req_drop    = drop_q;

endmodule

// File: doc/digests_responder.md
Name: digests_responder

Overview:
Parametrised GET_DIGESTS responder for the USB Type-C authentication driver. On a request it snapshots the per-slot certificate-chain digests and slot-populated mask, then streams a DIGESTS response (4-byte header, then one digest per populated slot) byte-serially over a valid/ready interface. Sits between the request decoder (drives req_in) and the response transmit path (consumes tx_*). Replaces the fixed-width, fixed-content answer block.

Parameters:
NUM_SLOTS, 8, number of certificate slots (1..8); width of slot mask
DIGEST_BYTES, 32, bytes per digest (1..64); digest sent MSB byte first
PROTO_VER, 8'h01, header byte 0 (ProtocolVersion)
MSG_TYPE, 8'h01, header byte 1 (MessageType for DIGESTS)
PARAM1, 8'h01, header byte 2 (Param1)
LEN_W, localparam = clog2(4 + NUM_SLOTS*DIGEST_BYTES + 1), length width

Ports:
clk  in  1  single clock, all state on rising edge
reset_L  in  1  asynchronous, active-low reset
req_in  in  1  GET_DIGESTS request strobe, one cycle
slot_mask_in  in  NUM_SLOTS  bit i = slot i populated
digest_in  in  NUM_SLOTS*DIGEST_BYTES*8  slot i digest at bits [(i+1)*DIGEST_BYTES*8-1 : i*DIGEST_BYTES*8]
tx_data  out  8  response byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte when tx_valid&&tx_ready
tx_sop  out  1  first byte of response (with tx_valid)
tx_eop  out  1  last byte of response (with tx_valid)
resp_len  out  LEN_W  total response bytes, valid while busy
busy  out  1  response in progress
done  out  1  one-cycle pulse, response complete
req_drop  out  1  one-cycle pulse, request arrived while not IDLE

Behaviour:
- Reset (reset_L low, async): state IDLE; all outputs 0; snapshot registers 0. Reset mid-response aborts it; no done, no eop.
- States: IDLE, HEADER, DIGEST, DONE.
- IDLE: req_in high at edge -> capture slot_mask_in and digest_in into snapshot regs, resp_len = 4 + popcount(mask)*DIGEST_BYTES, byte counter 0, -> HEADER. busy=1 from next cycle.
- HEADER: bytes in order PROTO_VER, MSG_TYPE, PARAM1, Param2 = snapshot mask zero-extended to 8 bits. tx_sop with byte 0 only. After byte 3 accepted: mask nonzero -> DIGEST at lowest populated slot; mask zero -> DONE (byte 3 carries tx_eop).
- DIGEST: slot digests in ascending slot index, skipping unpopulated slots; each digest MSB byte first, DIGEST_BYTES bytes. After last byte of a slot, advance to next higher populated slot (no idle cycle between slots). tx_eop on last byte of highest populated slot; after it is accepted -> DONE.
- DONE: one cycle, done=1, busy=0, tx_valid=0; -> IDLE.
- Handshake: tx_valid asserted continuously in HEADER/DIGEST; tx_data/tx_sop/tx_eop held stable while tx_valid&&!tx_ready; advance only on accept. Back-to-back accepts give one byte per cycle.
- Latency: req_in at edge N -> first byte valid cycle N+1.
- req_in while state != IDLE (incl. DONE): ignored, req_drop pulses next cycle; snapshot unchanged.
- Input changes on slot_mask_in/digest_in after capture have no effect on the ongoing response.
- Mask bits above NUM_SLOTS in Param2 are 0.

Decomposition:
- Shared defines file: header byte constants (protocol version, DIGESTS message type), SIZE_OF_HEADER_IN_BYTES=4, state encodings.
- Sub-module digest_slot_sel: combinational priority encoder, given snapshot mask and current slot, returns next higher populated slot index and last-slot flag.

Test Plan:
- NUM_SLOTS=3, DIGEST_BYTES=4, mask 3'b111, digests 0x04568787/0xAC786425/0x0F986550 (slots 0/1/2), tx_ready=1 -> 16 bytes 01 01 01 07 87 87 56 04-order per MSB-first i.e. 04 56 87 87, then AC 78 64 25, 0F 98 65 50; sop on byte 0, eop on byte 15, resp_len=16, done cycle after.
- Same, mask 3'b101 -> 12 bytes, Param2=05, slot 1 skipped, eop on last byte of slot 2.
- Mask 0 -> 4 bytes 01 01 01 00, eop on byte 3, resp_len=4.
- tx_ready toggling 1,0,0,1,... -> tx_data/eop stable through stalls, byte sequence identical to case 1.
- req_in pulsed mid-response and in DONE cycle -> req_drop pulses each time, response unchanged; digest_in changed after capture -> no effect.
- reset_L low mid-DIGEST -> tx_valid/busy/done 0 immediately; new req after release gives full correct response.
